// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use and branch stalls, and a
// divide sequencer that holds the pipeline while a multi-cycle divider runs.
module hazard_unit #(
  parameter int unsigned DIV_TIMEOUT = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       branchD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       divE,
  input  logic       div_ready,
  output logic       forwardaD,
  output logic       forwardbD,
  output logic [1:0] forwardaE,
  output logic [1:0] forwardbE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushE,
  output logic       flushM,
  output logic       div_start,
  output logic       div_err
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } state_e;

  localparam logic [5:0] TimeoutVal = 6'(DIV_TIMEOUT);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [5:0] cnt_inc;
  logic       timeout_hit;

  logic       lwstall;
  logic       branchstall;
  logic       hazard;

  // Register 0 is hardwired to zero, so it never carries a dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] dst_m, input logic wr_m,
                                         input logic [4:0] dst_w, input logic wr_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && reg_match(src, dst_m)) begin
      sel = 2'b10;
    end else if (wr_w && reg_match(src, dst_w)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  always_comb begin
    forwardaE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
    forwardbE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
    forwardaD = regwriteM & reg_match(rsD, writeregM);
    forwardbD = regwriteM & reg_match(rtD, writeregM);
  end

  // ---------------------------------------------------------------------------
  // Data hazards
  // ---------------------------------------------------------------------------
  always_comb begin
    lwstall     = memtoregE & regwriteE &
                  (reg_match(rsD, writeregE) | reg_match(rtD, writeregE));
    branchstall = branchD &
                  ((regwriteE & (reg_match(rsD, writeregE) | reg_match(rtD, writeregE))) |
                   (memtoregM & (reg_match(rsD, writeregM) | reg_match(rtD, writeregM))));
    hazard      = lwstall | branchstall;
  end

  // ---------------------------------------------------------------------------
  // Divide sequencer
  // ---------------------------------------------------------------------------
  assign cnt_inc     = cnt_q + 6'd1;
  // The timeout fires on the BUSY cycle whose increment would reach the limit,
  // so BUSY lasts exactly DIV_TIMEOUT cycles when the divider never answers.
  assign timeout_hit = (cnt_inc == TimeoutVal);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (divE) begin
          state_d = StBusy;
          cnt_d   = 6'd0;
        end
      end
      StBusy: begin
        if (div_ready) begin
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d = StDone;
          err_d   = 1'b1;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    stallF    = hazard;
    stallD    = hazard;
    stallE    = 1'b0;
    flushE    = hazard;
    flushM    = 1'b0;
    div_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        div_start = divE & ~rst;
      end
      StBusy: begin
        // The divide owns E; younger hazards wait until it retires.
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        flushE = 1'b0;
        flushM = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign div_err = err_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: expected output vectors are queued as
// stimulus is applied and popped when the outputs are sampled.
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic       branchD;
  logic [4:0] writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW;
  logic       memtoregE, memtoregM;
  logic       divE, div_ready;
  logic       forwardaD, forwardbD;
  logic [1:0] forwardaE, forwardbE;
  logic       stallF, stallD, stallE, flushE, flushM;
  logic       div_start, div_err;

  int unsigned checks = 0;
  int unsigned passes = 0;
  logic [12:0] sb[$];
  logic [12:0] exp_v, obs_v;
  logic        err_m;

  hazard_unit #(.DIV_TIMEOUT(63)) dut (
    .clk       (clk),
    .rst       (rst),
    .rsD       (rsD),
    .rtD       (rtD),
    .branchD   (branchD),
    .rsE       (rsE),
    .rtE       (rtE),
    .writeregE (writeregE),
    .writeregM (writeregM),
    .writeregW (writeregW),
    .regwriteE (regwriteE),
    .regwriteM (regwriteM),
    .regwriteW (regwriteW),
    .memtoregE (memtoregE),
    .memtoregM (memtoregM),
    .divE      (divE),
    .div_ready (div_ready),
    .forwardaD (forwardaD),
    .forwardbD (forwardbD),
    .forwardaE (forwardaE),
    .forwardbE (forwardbE),
    .stallF    (stallF),
    .stallD    (stallD),
    .stallE    (stallE),
    .flushE    (flushE),
    .flushM    (flushM),
    .div_start (div_start),
    .div_err   (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector order: faE[2], fbE[2], faD, fbD, stallF, stallD, stallE, flushE, flushM,
  // div_start, div_err
  function automatic logic [12:0] dut_vec();
    return {forwardaE, forwardbE, forwardaD, forwardbD, stallF, stallD, stallE,
            flushE, flushM, div_start, div_err};
  endfunction

  function automatic logic mt(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] r);
    if (regwriteM && mt(r, writeregM)) return 2'b10;
    if (regwriteW && mt(r, writeregW)) return 2'b01;
    return 2'b00;
  endfunction

  // Reference model of the outputs given the sequencer phase the bench expects.
  function automatic logic [12:0] exp_vec(input logic busy, input logic ds, input logic de);
    logic lw, br, hz;
    lw = memtoregE & regwriteE & (mt(rsD, writeregE) | mt(rtD, writeregE));
    br = branchD & ((regwriteE & (mt(rsD, writeregE) | mt(rtD, writeregE))) |
                    (memtoregM & (mt(rsD, writeregM) | mt(rtD, writeregM))));
    hz = lw | br;
    return {fwd_e(rsE), fwd_e(rtE), regwriteM & mt(rsD, writeregM),
            regwriteM & mt(rtD, writeregM), busy | hz, busy | hz, busy,
            ~busy & hz, busy, ds, de};
  endfunction

  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; branchD = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0; divE = 0; div_ready = 0;
  endtask

  task automatic push_model(input logic busy, input logic ds);
    sb.push_back(exp_vec(busy, ds, err_m));
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    divE = 1'b1;
    repeat (2) @(negedge clk);
    // rst still high, state IDLE, divE high: no launch allowed
    sb.push_back(13'b0);
    #1;
    exp_v = sb.pop_front(); obs_v = dut_vec(); checks++;
    if (obs_v !== exp_v) $display("FAIL reset_hold: got %b want %b", obs_v, exp_v);
    else passes++;
    @(negedge clk);
    rst = 1'b0; divE = 1'b0; err_m = 1'b0;
    sb.push_back(13'b0);
    #1;
    exp_v = sb.pop_front(); obs_v = dut_vec(); checks++;
    if (obs_v !== exp_v) $display("FAIL reset_idle: got %b want %b", obs_v, exp_v);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_load_use();
    clear_inputs();
    memtoregE = 1; regwriteE = 1; writeregE = 5'd2; rsD = 5'd2;
    sb.push_back({2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    #1;
    exp_v = sb.pop_front(); obs_v = dut_vec(); checks++;
    if (obs_v !== exp_v) $display("FAIL load_use: got %b want %b", obs_v, exp_v);
    else passes++;
    @(negedge clk);
    rsD = 5'd0; rtD = 5'd2;
    sb.push_back({2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    #1;
    exp_v = sb.pop_front(); obs_v = dut_vec(); checks++;
    if (obs_v !== exp_v) $display("FAIL load_use_rt: got %b want %b", obs_v, exp_v);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_branch_stall();
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      if (i == 0) begin
        branchD = 1; regwriteE = 1; writeregE = 5'd7; rtD = 5'd7;
        sb.push_back({2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      end else if (i == 1) begin
        branchD = 1; memtoregM = 1; regwriteM = 1; writeregM = 5'd9; rsD = 5'd9;
        sb.push_back({2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      end else begin
        memtoregM = 1; regwriteM = 1; writeregM = 5'd9; rsD = 5'd9;
        sb.push_back({2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      end
      #1;
      exp_v = sb.pop_front(); obs_v = dut_vec(); checks++;
      if (obs_v !== exp_v) $display("FAIL branch_stall[%0d]: got %b want %b", i, obs_v, exp_v);
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_forward_priority();
    clear_inputs();
    regwriteM = 1; writeregM = 5'd5; regwriteW = 1; writeregW = 5'd5; rsE = 5'd5;
    sb.push_back({2'b10, 2'b00, 9'b0});
    #1;
    exp_v = sb.pop_front(); obs_v = dut_vec(); checks++;
    if (obs_v !== exp_v) $display("FAIL fwd_prio_m: got %b want %b", obs_v, exp_v);
    else passes++;
    regwriteM = 0; rtE = 5'd5;
    sb.push_back({2'b01, 2'b01, 9'b0});
    #1;
    exp_v = sb.pop_front(); obs_v = dut_vec(); checks++;
    if (obs_v !== exp_v) $display("FAIL fwd_prio_w: got %b want %b", obs_v, exp_v);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_reg_zero();
    clear_inputs();
    regwriteM = 1; writeregM = 5'd0; regwriteW = 1; writeregW = 5'd0;
    regwriteE = 1; memtoregE = 1; writeregE = 5'd0; branchD = 1;
    sb.push_back(13'b0);
    #1;
    exp_v = sb.pop_front(); obs_v = dut_vec(); checks++;
    if (obs_v !== exp_v) $display("FAIL reg_zero: got %b want %b", obs_v, exp_v);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_forward_random();
    for (int i = 0; i < 40; i++) begin
      clear_inputs();
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
      memtoregE = 1'($urandom); memtoregM = 1'($urandom); branchD = 1'($urandom);
      push_model(1'b0, 1'b0);
      #1;
      exp_v = sb.pop_front(); obs_v = dut_vec(); checks++;
      if (obs_v !== exp_v) $display("FAIL fwd_rand[%0d]: got %b want %b", i, obs_v, exp_v);
      else passes++;
      @(negedge clk);
    end
  endtask

  // One divide: launch, busy_len BUSY cycles (ready on the last if with_ready),
  // DONE with divE still high, then IDLE with divE low.
  task automatic run_divide(input string name, input int busy_len, input logic with_ready,
                            input logic hazard_in_busy);
    int total;
    total = busy_len + 3;
    for (int c = 0; c < total; c++) begin
      clear_inputs();
      divE = (c <= busy_len + 1);
      if (hazard_in_busy && c >= 2 && c <= 4) begin
        memtoregE = 1; regwriteE = 1; writeregE = 5'd3; rsD = 5'd3;
      end
      if (c == busy_len && with_ready) div_ready = 1'b1;
      if (c == 0) div_ready = 1'b1;
      if (c == busy_len + 1 && !with_ready) err_m = 1'b1;
      push_model(c >= 1 && c <= busy_len, c == 0);
      #1;
      exp_v = sb.pop_front(); obs_v = dut_vec(); checks++;
      if (obs_v !== exp_v) $display("FAIL %s cyc%0d: got %b want %b", name, c, obs_v, exp_v);
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_divide();
    run_divide("divide", 10, 1'b1, 1'b1);
  endtask

  task automatic test_ready_at_timeout();
    run_divide("ready_at_timeout", 63, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    run_divide("timeout", 63, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_divide("b2b_a", 2, 1'b1, 1'b0);
    run_divide("b2b_b", 1, 1'b1, 1'b0);
    // A stray ready in IDLE must not disturb the sequencer.
    clear_inputs();
    div_ready = 1'b1;
    push_model(1'b0, 1'b0);
    #1;
    exp_v = sb.pop_front(); obs_v = dut_vec(); checks++;
    if (obs_v !== exp_v) $display("FAIL idle_ready: got %b want %b", obs_v, exp_v);
    else passes++;
    @(negedge clk);
    div_ready = 1'b0;
    push_model(1'b0, 1'b0);
    #1;
    exp_v = sb.pop_front(); obs_v = dut_vec(); checks++;
    if (obs_v !== exp_v) $display("FAIL idle_after_ready: got %b want %b", obs_v, exp_v);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_divide();
    for (int c = 0; c < 8; c++) begin
      clear_inputs();
      divE = (c <= 4);
      rst = (c == 4);
      if (c == 6) div_ready = 1'b1;
      if (c == 5) err_m = 1'b0;
      push_model(c >= 1 && c <= 4, c == 0);
      #1;
      exp_v = sb.pop_front(); obs_v = dut_vec(); checks++;
      if (obs_v !== exp_v) $display("FAIL rst_mid_div cyc%0d: got %b want %b", c, obs_v, exp_v);
      else passes++;
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    err_m = 1'b0;
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch_stall();
    test_forward_priority();
    test_reg_zero();
    test_forward_random();
    test_divide();
    test_ready_at_timeout();
    test_timeout();
    test_back_to_back();
    test_reset_mid_divide();
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
